// File: rtl/frv_clmul_mc.sv
// Multi-cycle carry-less multiplier (clmul / clmulh / clmulr) consuming BPC multiplier bits per cycle.
// Optional macro FRV_CLMUL_EARLY_EXIT_EN: finish as soon as the remaining multiplier bits are all zero.
module frv_clmul_mc #(
  parameter int XLEN = 32,
  parameter int BPC  = 1
) (
  input  logic            g_clk,
  input  logic            g_rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            op_clmul,
  input  logic            op_clmulh,
  input  logic            op_clmulr,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result
);

  localparam int STEPS = XLEN / BPC;
  localparam int CW    = $clog2(STEPS) + 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(STEPS);

  generate
    if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
      $error("frv_clmul_mc: XLEN must be 32 or 64");
    end
    if ((BPC != 1 && BPC != 2 && BPC != 4 && BPC != 8) || (XLEN % BPC) != 0) begin : g_bad_bpc
      $error("frv_clmul_mc: BPC must be 1, 2, 4 or 8 and divide XLEN");
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    OP_CLMUL  = 2'd0,
    OP_CLMULH = 2'd1,
    OP_CLMULR = 2'd2
  } op_t;

  state_t            state, state_d;
  op_t               op_sel, op_d, op_dec;
  logic [2*XLEN-1:0] acc, acc_d, acc_step;
  logic [2*XLEN-1:0] a_sh, a_sh_d, a_sh_next;
  logic [XLEN-1:0]   b_sh, b_sh_d, b_sh_next;
  logic [CW-1:0]     cnt, cnt_d, cnt_next;
  logic              busy_last;

  // clmul wins over clmulh over clmulr; no op bit at all also means clmul.
  always_comb begin
    op_dec = OP_CLMUL;
    if (op_clmul)
      op_dec = OP_CLMUL;
    else if (op_clmulh)
      op_dec = OP_CLMULH;
    else if (op_clmulr)
      op_dec = OP_CLMULR;
  end

  always_comb begin
    acc_step = acc;
    for (int j = 0; j < BPC; j++) begin
      if (b_sh[j])
        acc_step = acc_step ^ (a_sh << j);
    end
  end

  assign a_sh_next = a_sh << BPC;
  assign b_sh_next = b_sh >> BPC;
  assign cnt_next  = cnt + CW'(1);

`ifdef FRV_CLMUL_EARLY_EXIT_EN
  assign busy_last = (cnt_next == LAST_CNT) || (b_sh_next == '0);
`else
  assign busy_last = (cnt_next == LAST_CNT);
`endif

  always_comb begin
    state_d   = state;
    acc_d     = acc;
    a_sh_d    = a_sh;
    b_sh_d    = b_sh;
    cnt_d     = cnt;
    op_d      = op_sel;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_d = ST_BUSY;
          acc_d   = '0;
          a_sh_d  = {{XLEN{1'b0}}, rs1};
          b_sh_d  = rs2;
          cnt_d   = '0;
          op_d    = op_dec;
        end
      end
      ST_BUSY: begin
        acc_d  = acc_step;
        a_sh_d = a_sh_next;
        b_sh_d = b_sh_next;
        cnt_d  = cnt_next;
        if (busy_last)
          state_d = ST_DONE;
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready)
          state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // A flush drops whatever is in flight, including an unconsumed result or a new request.
    if (flush) begin
      state_d = ST_IDLE;
      acc_d   = '0;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge g_clk) begin
    if (g_rst) begin
      state  <= ST_IDLE;
      acc    <= '0;
      a_sh   <= '0;
      b_sh   <= '0;
      cnt    <= '0;
      op_sel <= OP_CLMUL;
    end else begin
      state  <= state_d;
      acc    <= acc_d;
      a_sh   <= a_sh_d;
      b_sh   <= b_sh_d;
      cnt    <= cnt_d;
      op_sel <= op_d;
    end
  end

  always_comb begin
    result = '0;
    if (state == ST_DONE) begin
      unique case (op_sel)
        OP_CLMULH: result = {1'b0, acc[2*XLEN-2:XLEN]};
        OP_CLMULR: result = acc[2*XLEN-2:XLEN-1];
        default:   result = acc[XLEN-1:0];
      endcase
    end
  end

endmodule

// File: tb/tb_frv_clmul_mc.sv
// Bench for frv_clmul_mc: a 32-bit/BPC=1 and a 64-bit/BPC=4 instance driven from a directed vector
// table, plus hand-written backpressure, flush and reset sequences.
module tb_frv_clmul_mc;

`ifdef FRV_CLMUL_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic        a_flush, a_in_valid, a_in_ready, a_clmul, a_clmulh, a_clmulr;
  logic        a_out_valid, a_out_ready;
  logic [31:0] a_rs1, a_rs2, a_result;

  logic        b_flush, b_in_valid, b_in_ready, b_clmul, b_clmulh, b_clmulr;
  logic        b_out_valid, b_out_ready;
  logic [63:0] b_rs1, b_rs2, b_result;

  frv_clmul_mc #(.XLEN(32), .BPC(1)) u_dut32 (
    .g_clk(clk), .g_rst(rst), .flush(a_flush),
    .in_valid(a_in_valid), .in_ready(a_in_ready),
    .op_clmul(a_clmul), .op_clmulh(a_clmulh), .op_clmulr(a_clmulr),
    .rs1(a_rs1), .rs2(a_rs2),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .result(a_result)
  );

  frv_clmul_mc #(.XLEN(64), .BPC(4)) u_dut64 (
    .g_clk(clk), .g_rst(rst), .flush(b_flush),
    .in_valid(b_in_valid), .in_ready(b_in_ready),
    .op_clmul(b_clmul), .op_clmulh(b_clmulh), .op_clmulr(b_clmulr),
    .rs1(b_rs1), .rs2(b_rs2),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .result(b_result)
  );

  typedef struct {
    bit          wide;
    logic [2:0]  ops;
    logic [63:0] rs1;
    logic [63:0] rs2;
    logic [63:0] expected;
    string       name;
  } vec_t;

  localparam int NV = 28;
  vec_t vecs[NV];

  int checks = 0;
  int errors = 0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: actual 0x%0h required 0x%0h", name, act, req);
    end
  endtask

  // Cycles from driving in_valid until out_valid is first seen, counting the acceptance edge.
  function automatic int exp_lat(input bit wide, input logic [63:0] rs2);
    int bpc, steps, msb, busy;
    bpc   = wide ? 4 : 1;
    steps = wide ? 16 : 32;
    msb   = -1;
    for (int i = 0; i < 64; i++)
      if (rs2[i]) msb = i;
    busy = (msb + bpc) / bpc;
    if (busy < 1) busy = 1;
    return EARLY ? busy + 1 : steps + 1;
  endfunction

  task automatic applyStimulus(input bit wide, input logic [2:0] ops, input logic [63:0] rs1,
                               input logic [63:0] rs2, output logic [63:0] res, output int lat);
    if (wide) begin
      {b_clmul, b_clmulh, b_clmulr} = ops;
      b_rs1 = rs1;
      b_rs2 = rs2;
      b_in_valid = 1'b1;
    end else begin
      {a_clmul, a_clmulh, a_clmulr} = ops;
      a_rs1 = rs1[31:0];
      a_rs2 = rs2[31:0];
      a_in_valid = 1'b1;
    end
    @(posedge clk); #1;
    a_in_valid = 1'b0;
    b_in_valid = 1'b0;
    {a_clmul, a_clmulh, a_clmulr} = 3'b000;
    {b_clmul, b_clmulh, b_clmulr} = 3'b000;
    lat = 1;
    while (!(wide ? b_out_valid : a_out_valid) && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    res = wide ? b_result : {32'b0, a_result};
  endtask

  logic [63:0] res;
  int          lat;
  int          seen;

  initial begin
    vecs[0]  = '{1'b0, 3'b100, 64'h3, 64'h3, 64'h5, "clmul_3x3"};
    vecs[1]  = '{1'b0, 3'b010, 64'h80000000, 64'h80000000, 64'h40000000, "clmulh_msb32"};
    vecs[2]  = '{1'b0, 3'b001, 64'h80000000, 64'h80000000, 64'h80000000, "clmulr_msb32"};
    vecs[3]  = '{1'b0, 3'b100, 64'h80000000, 64'h80000000, 64'h0, "clmul_msb32"};
    vecs[4]  = '{1'b0, 3'b100, 64'hFFFFFFFF, 64'h3, 64'h1, "clmul_ones_x3_32"};
    vecs[5]  = '{1'b0, 3'b010, 64'hFFFFFFFF, 64'h3, 64'h1, "clmulh_ones_x3_32"};
    vecs[6]  = '{1'b0, 3'b001, 64'hFFFFFFFF, 64'h3, 64'h2, "clmulr_ones_x3_32"};
    vecs[7]  = '{1'b0, 3'b000, 64'h3, 64'h3, 64'h5, "noop_is_clmul"};
    vecs[8]  = '{1'b0, 3'b011, 64'h80000000, 64'h80000000, 64'h40000000, "prio_h_over_r"};
    vecs[9]  = '{1'b0, 3'b111, 64'h3, 64'h3, 64'h5, "prio_all_clmul"};
    vecs[10] = '{1'b0, 3'b100, 64'h12345678, 64'h1, 64'h12345678, "rs2_one"};
    vecs[11] = '{1'b0, 3'b100, 64'hDEADBEEF, 64'h0, 64'h0, "rs2_zero"};
    vecs[12] = '{1'b0, 3'b100, 64'h00010001, 64'h00010001, 64'h1, "clmul_sq_10001"};
    vecs[13] = '{1'b0, 3'b010, 64'h00010001, 64'h00010001, 64'h1, "clmulh_sq_10001"};
    vecs[14] = '{1'b0, 3'b100, 64'h1, 64'h80000000, 64'h80000000, "clmul_rs2_msb"};
    vecs[15] = '{1'b0, 3'b001, 64'h1, 64'h80000000, 64'h1, "clmulr_rs2_msb"};
    vecs[16] = '{1'b1, 3'b100, 64'hFFFFFFFFFFFFFFFF, 64'h3, 64'h1, "clmul_ones_x3_64"};
    vecs[17] = '{1'b1, 3'b010, 64'hFFFFFFFFFFFFFFFF, 64'h3, 64'h1, "clmulh_ones_x3_64"};
    vecs[18] = '{1'b1, 3'b001, 64'hFFFFFFFFFFFFFFFF, 64'h3, 64'h2, "clmulr_ones_x3_64"};
    vecs[19] = '{1'b1, 3'b010, 64'h8000000000000000, 64'h8000000000000000, 64'h4000000000000000, "clmulh_msb64"};
    vecs[20] = '{1'b1, 3'b001, 64'h8000000000000000, 64'h8000000000000000, 64'h8000000000000000, "clmulr_msb64"};
    vecs[21] = '{1'b1, 3'b100, 64'h5, 64'h3, 64'hF, "clmul_5x3_64"};
    vecs[22] = '{1'b1, 3'b100, 64'h0123456789ABCDEF, 64'h1, 64'h0123456789ABCDEF, "rs2_one_64"};
    vecs[23] = '{1'b1, 3'b100, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 64'h5555555555555555, "clmul_sq_ones64"};
    vecs[24] = '{1'b1, 3'b010, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 64'h5555555555555555, "clmulh_sq_ones64"};
    vecs[25] = '{1'b1, 3'b001, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 64'hAAAAAAAAAAAAAAAA, "clmulr_sq_ones64"};
    vecs[26] = '{1'b0, 3'b100, 64'hFFFFFFFF, 64'hFFFFFFFF, 64'h55555555, "clmul_sq_ones32"};
    vecs[27] = '{1'b0, 3'b001, 64'hFFFFFFFF, 64'hFFFFFFFF, 64'hAAAAAAAA, "clmulr_sq_ones32"};

    rst = 1'b1;
    a_flush = 1'b0; a_in_valid = 1'b0; a_clmul = 1'b0; a_clmulh = 1'b0; a_clmulr = 1'b0;
    a_rs1 = '0; a_rs2 = '0; a_out_ready = 1'b1;
    b_flush = 1'b0; b_in_valid = 1'b0; b_clmul = 1'b0; b_clmulh = 1'b0; b_clmulr = 1'b0;
    b_rs1 = '0; b_rs2 = '0; b_out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    checkOutput("reset_in_ready32", 64'(a_in_ready), 64'h1);
    checkOutput("reset_out_valid32", 64'(a_out_valid), 64'h0);
    checkOutput("reset_result32", 64'(a_result), 64'h0);
    checkOutput("reset_in_ready64", 64'(b_in_ready), 64'h1);
    checkOutput("reset_out_valid64", 64'(b_out_valid), 64'h0);
    checkOutput("reset_result64", b_result, 64'h0);

    for (int i = 0; i < NV; i++) begin
      applyStimulus(vecs[i].wide, vecs[i].ops, vecs[i].rs1, vecs[i].rs2, res, lat);
      checkOutput({vecs[i].name, "_result"}, res, vecs[i].expected);
      checkOutput({vecs[i].name, "_latency"}, 64'(lat), 64'(exp_lat(vecs[i].wide, vecs[i].rs2)));
      @(posedge clk); #1;
    end

    // Backpressure: result must hold in DONE until out_ready, then IDLE on the next cycle.
    a_out_ready = 1'b0;
    applyStimulus(1'b0, 3'b100, 64'h3, 64'h3, res, lat);
    checkOutput("bp_result", res, 64'h5);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      checkOutput("bp_hold_valid", 64'(a_out_valid), 64'h1);
      checkOutput("bp_hold_result", 64'(a_result), 64'h5);
      checkOutput("bp_hold_in_ready", 64'(a_in_ready), 64'h0);
    end
    a_out_ready = 1'b1;
    @(posedge clk); #1;
    checkOutput("bp_release_in_ready", 64'(a_in_ready), 64'h1);
    checkOutput("bp_release_valid", 64'(a_out_valid), 64'h0);

    // Flush in the fifth BUSY cycle, then a fresh request must give only its own result.
    a_clmul = 1'b1; a_rs1 = 32'hFFFFFFFF; a_rs2 = 32'hFFFFFFFF; a_in_valid = 1'b1;
    @(posedge clk); #1;
    a_in_valid = 1'b0; a_clmul = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    a_flush = 1'b1;
    @(posedge clk); #1;
    a_flush = 1'b0;
    checkOutput("flush_busy_in_ready", 64'(a_in_ready), 64'h1);
    checkOutput("flush_busy_valid", 64'(a_out_valid), 64'h0);
    checkOutput("flush_busy_result", 64'(a_result), 64'h0);
    applyStimulus(1'b0, 3'b100, 64'h5, 64'h3, res, lat);
    checkOutput("after_flush_result", res, 64'hF);
    checkOutput("after_flush_latency", 64'(lat), 64'(exp_lat(1'b0, 64'h3)));
    @(posedge clk); #1;

    // Same scenario with reset in place of flush.
    a_clmul = 1'b1; a_rs1 = 32'hFFFFFFFF; a_rs2 = 32'hFFFFFFFF; a_in_valid = 1'b1;
    @(posedge clk); #1;
    a_in_valid = 1'b0; a_clmul = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checkOutput("rst_busy_in_ready", 64'(a_in_ready), 64'h1);
    checkOutput("rst_busy_valid", 64'(a_out_valid), 64'h0);
    checkOutput("rst_busy_result", 64'(a_result), 64'h0);
    applyStimulus(1'b0, 3'b100, 64'h5, 64'h3, res, lat);
    checkOutput("after_rst_result", res, 64'hF);
    checkOutput("after_rst_latency", 64'(lat), 64'(exp_lat(1'b0, 64'h3)));
    @(posedge clk); #1;

    // Flush together with in_valid in IDLE: the request must be dropped.
    a_clmul = 1'b1; a_rs1 = 32'h3; a_rs2 = 32'h3; a_in_valid = 1'b1; a_flush = 1'b1;
    @(posedge clk); #1;
    a_in_valid = 1'b0; a_clmul = 1'b0; a_flush = 1'b0;
    checkOutput("flush_idle_in_ready", 64'(a_in_ready), 64'h1);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (a_out_valid) seen++;
    end
    checkOutput("flush_idle_no_result", 64'(seen), 64'h0);

    // Flush with out_ready in DONE: treated as a flush, unit returns to IDLE.
    a_out_ready = 1'b0;
    applyStimulus(1'b0, 3'b010, 64'h80000000, 64'h80000000, res, lat);
    checkOutput("flush_done_result", res, 64'h40000000);
    a_flush = 1'b1; a_out_ready = 1'b1;
    @(posedge clk); #1;
    a_flush = 1'b0;
    checkOutput("flush_done_valid", 64'(a_out_valid), 64'h0);
    checkOutput("flush_done_in_ready", 64'(a_in_ready), 64'h1);
    checkOutput("flush_done_result_zero", 64'(a_result), 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/frv_clmul_mc.md
Name: frv_clmul_mc

Overview:
- Parametrised, multi-cycle carry-less multiply unit for the execute stage. It implements clmul, clmulh and clmulr at XLEN 32 or 64.
- Sits beside the single-cycle ALU, which has no clmul support.
- Processes BPC multiplier bits per cycle behind a valid/ready handshake on both the request and response sides.
- The pipeline can squash an in-flight operation with a flush.

Parameters:
XLEN, 32, operand/result width; legal values 32 or 64.
BPC, 1, multiplier bits consumed per cycle; legal values 1, 2, 4, 8; XLEN % BPC == 0 (elaboration error otherwise).

Ports:
g_clk      in   1     core clock; all state updates on rising edge.
g_rst      in   1     synchronous, active-high reset.
flush      in   1     abandon any in-flight or completed operation.
in_valid   in   1     request valid.
in_ready   out  1     unit can accept a request (high only in IDLE).
op_clmul   in   1     select low half of product.
op_clmulh  in   1     select high half of product.
op_clmulr  in   1     select reversed (bits 2*XLEN-2 : XLEN-1).
rs1        in   XLEN  multiplicand.
rs2        in   XLEN  multiplier.
out_valid  out  1     result valid (high only in DONE).
out_ready  in   1     consumer accepts result.
result     out  XLEN  selected product slice; zero when out_valid low.

Behaviour:
- State machine: IDLE, BUSY, DONE.
- Registered state: acc (2*XLEN bits), a_sh (2*XLEN bits, rs1 shifted), b_sh (XLEN bits, rs2 shifted), cnt (log2(XLEN/BPC)+1 bits), 2-bit op select.
- Reset (g_rst=1 at an edge): state=IDLE, acc=0, cnt=0, op select=0. Outputs after reset: in_ready=1, out_valid=0, result=0. Reset takes priority over flush and all handshakes.

IDLE:
- in_ready=1.
- On in_valid=1 (and no flush): capture acc=0, a_sh={XLEN'b0,rs1}, b_sh=rs2, cnt=0, op; go to BUSY.
- If no op_* bit is set, treat the request as clmul.
- If more than one op_* bit is set, priority is clmul > clmulh > clmulr.

BUSY:
- Each cycle, for j in 0..BPC-1: if b_sh[j], acc ^= a_sh << j.
- Then a_sh <<= BPC, b_sh >>= BPC, cnt += 1.
- After XLEN/BPC BUSY cycles go to DONE.
- in_ready=0 and out_valid=0 throughout.

DONE:
- out_valid=1. result is:
  - clmul: acc[XLEN-1:0]
  - clmulh: {1'b0, acc[2*XLEN-2:XLEN]}
  - clmulr: acc[2*XLEN-2:XLEN-1]
- Result is held stable while out_ready=0.
- On out_ready=1, go to IDLE. There is no same-cycle re-accept: in_ready is low in DONE.

Latency (fixed, without the optional feature):
- Request accepted at edge 0; out_valid rises after edge XLEN/BPC+1.
- BPC=1, XLEN=32: 32 BUSY cycles, so out_valid first visible 33 cycles after acceptance.

flush:
- In any state, flush=1 at an edge forces IDLE. acc and cnt are discarded and out_valid drops the next cycle.
- flush=1 in IDLE with in_valid=1: the request is not accepted.
- flush and out_ready together in DONE: treated as flush; the result is counted as not consumed.

Arithmetic:
- All XOR, no carries.
- Bit 2*XLEN-1 of acc is always 0.
- Operands are treated as unsigned bit vectors.

Optional Feature:
Macro FRV_CLMUL_EARLY_EXIT_EN.
- Defined: in BUSY, if the next-cycle b_sh is zero, go to DONE at that edge regardless of cnt. Latency becomes ceil((msb_index(rs2)+1)/BPC)+1 cycles.
  - rs2=0 still takes exactly one BUSY cycle and gives result=0.
  - Result values are identical to the fixed-latency build.
- Undefined: always exactly XLEN/BPC BUSY cycles; no zero-detect logic on b_sh.

Test Plan:
- XLEN=32, BPC=1, clmul rs1=0x00000003 rs2=0x00000003, out_ready=1 -> result=0x00000005. out_valid asserted exactly 33 cycles after acceptance (without FRV_CLMUL_EARLY_EXIT_EN).
- XLEN=32, rs1=0x80000000 rs2=0x80000000:
  - clmulh -> 0x40000000.
  - clmulr -> 0x80000000.
  - clmul -> 0x00000000.
- XLEN=64, BPC=4, rs1=0xFFFFFFFFFFFFFFFF rs2=0x3:
  - clmul -> 0x0000000000000001.
  - clmulh -> 0x0000000000000001.
  - 16 BUSY cycles.
- Backpressure: hold out_ready=0 for 10 cycles in DONE -> out_valid and result stable, in_ready=0. Then out_ready=1 -> IDLE next cycle with in_ready=1.
- flush asserted at BUSY cycle 5, then a new clmul rs1=0x5 rs2=0x3 issued -> no stale result ever presented; result=0x0000000F. Repeat the scenario with g_rst instead of flush -> outputs at reset values the following cycle.
- With FRV_CLMUL_EARLY_EXIT_EN, BPC=1:
  - rs2=0x1 -> DONE after 1 BUSY cycle, result=rs1.
  - rs2=0x0 -> 1 BUSY cycle, result=0.
  - rs2=0x80000000 -> 32 BUSY cycles.
